// File: rtl/uart_pkg.sv
// Shared types and helpers for the buffered UART transmitter.
package uart_pkg;

  typedef enum logic [1:0] {
    NONE = 2'd0,
    ODD  = 2'd1,
    EVEN = 2'd2
  } parity_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } uart_tx_state_t;

  // Clock cycles per bit, rounded to nearest.
  function automatic int calc_spb(input int clk_freq, input int baud_rate);
    return (clk_freq + baud_rate / 2) / baud_rate;
  endfunction

endpackage

// File: rtl/uart_tx_fifo_if.sv
// Write-side handshake of the UART transmitter.
interface uart_tx_fifo_if #(
  parameter int DATA_BITS = 8
);
  logic                 i_data_valid;
  logic [DATA_BITS-1:0] i_data;
  logic                 o_data_ready;

  modport master (output i_data_valid, i_data, input o_data_ready);
  modport slave  (input i_data_valid, i_data, output o_data_ready);
endinterface

// File: rtl/sync_fifo.sv
// Single-clock FIFO: valid/ready push, pop strobe, occupancy count.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       n_rst,
  input  logic                       push_valid,
  output logic                       push_ready,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           pop_data,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       empty,
  output logic                       full
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic             do_push, do_pop;

  assign empty      = (count == '0);
  assign full       = (count == FULL_CNT);
  assign push_ready = ~full;
  assign do_push    = push_valid & push_ready;
  assign do_pop     = pop & ~empty;
  assign pop_data   = mem[rd_ptr];

  // Pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset; entries are only read after being written.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/uart_tx_fifo.sv
// Buffered UART transmitter: FIFO, CTS synchroniser, bit timer, shifter, FSM.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = 50000000,
  parameter int BAUD_RATE  = 115200,
  parameter int DATA_BITS  = 8,
  parameter int STOP_BITS  = 1,
  parameter int PARITY     = 0,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          n_rst,
  uart_tx_fifo_if.slave                 bus,
  input  logic                          i_cts_n,
  output logic [$clog2(FIFO_DEPTH):0]   o_fifo_count,
  output logic                          o_busy,
  output logic                          o_tx
);
  localparam int SPB = calc_spb(CLK_FREQ, BAUD_RATE);
  localparam int CW  = (SPB > 1) ? $clog2(SPB) : 1;
  localparam bit PAR_EN  = (PARITY != int'(NONE));
  localparam bit PAR_ODD = (PARITY == int'(ODD));

  uart_tx_state_t       state, state_d;
  logic [CW-1:0]        smp_cnt;
  logic [3:0]           bit_cnt;
  logic [DATA_BITS-1:0] shift_q, fifo_data;
  logic                 par_q, tx_q;
  logic                 cts_meta, cts_sync, cts_ok;
  logic                 fifo_empty, fifo_full, fifo_ready, load, bit_end;

  sync_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk        (clk),
    .n_rst      (n_rst),
    .push_valid (bus.i_data_valid),
    .push_ready (fifo_ready),
    .push_data  (bus.i_data),
    .pop        (load),
    .pop_data   (fifo_data),
    .count      (o_fifo_count),
    .empty      (fifo_empty),
    .full       (fifo_full)
  );

  assign bus.o_data_ready = fifo_ready;
  assign o_busy  = (state != ST_IDLE) | ~fifo_empty;
  assign o_tx    = tx_q;
  assign cts_ok  = ~cts_sync;
  assign bit_end = (state != ST_IDLE) && (smp_cnt == CW'(SPB - 1));

  // A full FIFO must never advertise space.
  a_full_not_ready: assert property (@(posedge clk) disable iff (!n_rst) fifo_full |-> !fifo_ready);

  // Two-flop CTS synchroniser; resets to "not clear".
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      cts_meta <= 1'b1;
      cts_sync <= 1'b1;
    end else begin
      cts_meta <= i_cts_n;
      cts_sync <= cts_meta;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) state <= ST_IDLE;
    else        state <= state_d;
  end

  // Next state and pop; CTS only matters at frame boundaries.
  always_comb begin
    state_d = state;
    load    = 1'b0;
    case (state)
      ST_IDLE: if (!fifo_empty && cts_ok) begin
        load    = 1'b1;
        state_d = ST_START;
      end
      ST_START:  if (bit_end) state_d = ST_DATA;
      ST_DATA:   if (bit_end && bit_cnt == 4'(DATA_BITS - 1))
                   state_d = PAR_EN ? ST_PARITY : ST_STOP;
      ST_PARITY: if (bit_end) state_d = ST_STOP;
      ST_STOP:   if (bit_end && bit_cnt == 4'(STOP_BITS - 1)) begin
        if (!fifo_empty && cts_ok) begin
          load    = 1'b1;
          state_d = ST_START;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Bit timer and per-state bit index.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      smp_cnt <= '0;
      bit_cnt <= '0;
    end else begin
      if (state == ST_IDLE || bit_end) smp_cnt <= '0;
      else                             smp_cnt <= smp_cnt + 1'b1;
      if (state_d != state) bit_cnt <= '0;
      else if (bit_end)     bit_cnt <= bit_cnt + 1'b1;
    end
  end

  // Shifter and parity are captured from the popped word.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      shift_q <= '0;
      par_q   <= 1'b0;
    end else if (load) begin
      shift_q <= fifo_data;
      par_q   <= PAR_ODD ? ~^fifo_data : ^fifo_data;
    end else if (state == ST_DATA && bit_end) begin
      shift_q <= shift_q >> 1;
    end
  end

  // Registered line driver, one cycle behind the FSM.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) tx_q <= 1'b1;
    else begin
      case (state)
        ST_START:  tx_q <= 1'b0;
        ST_DATA:   tx_q <= shift_q[0];
        ST_PARITY: tx_q <= par_q;
        default:   tx_q <= 1'b1;
      endcase
    end
  end

endmodule
